serial_compare_ctrl: RTL and testbench

SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

---
 rtl/serial_compare_ctrl_if.sv | 33 +++
 rtl/serial_compare_ctrl.sv | 95 +++++++++
 tb/tb_serial_compare_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_compare_ctrl_if.sv
// Bundle between the bit-serial compare controller and its requester / 1-bit cell.
// slave = controller side, master = requester plus comparator cell side.
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bit_a;
  logic             bit_b;
  logic             cas_eq;
  logic             cas_gt;
  logic             cas_lt;
  logic             cell_eq;
  logic             cell_gt;
  logic             cell_lt;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;
  logic             err;

  modport slave (
    input  start, a, b, cell_eq, cell_gt, cell_lt,
    output bit_a, bit_b, cas_eq, cas_gt, cas_lt, busy, done, eq, gt, lt, err
  );

  modport master (
    output start, a, b, cell_eq, cell_gt, cell_lt,
    input  bit_a, bit_b, cas_eq, cas_gt, cas_lt, busy, done, eq, gt, lt, err
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned magnitude comparator controller: feeds operand bits MSB-first
// to an external 1-bit cascade cell and accumulates its {eq,gt,lt} result.
module serial_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_compare_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       cas_q;   // {eq, gt, lt}
  logic [2:0]       res_q;   // {eq, gt, lt}
  logic             err_q;

  logic [2:0] cas_d;
  logic       last_bit_d;
  logic       exit_d;

  assign cas_d      = {bus.cell_eq, bus.cell_gt, bus.cell_lt};
  assign last_bit_d = (cnt_q == CW'(1));
  // Once the cascade is no longer equal, later bits cannot change the verdict.
  assign exit_d     = last_bit_d || (EARLY_EXIT && !bus.cell_eq);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      cas_q   <= 3'b100;
      res_q   <= 3'b000;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            cas_q   <= 3'b100;
            cnt_q   <= CW'(WIDTH);
            res_q   <= 3'b000;
            err_q   <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          cas_q <= cas_d;
          a_q   <= {a_q[WIDTH-2:0], 1'b0};
          b_q   <= {b_q[WIDTH-2:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
          if (!$onehot(cas_d)) begin
            err_q <= 1'b1;
          end
          if (exit_d) begin
            res_q   <= cas_d;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic in_run;
  assign in_run = (state_q == RUN);

  assign bus.bit_a  = in_run & a_q[WIDTH-1];
  assign bus.bit_b  = in_run & b_q[WIDTH-1];
  assign bus.cas_eq = in_run & cas_q[2];
  assign bus.cas_gt = in_run & cas_q[1];
  assign bus.cas_lt = in_run & cas_q[0];
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.eq     = res_q[2];
  assign bus.gt     = res_q[1];
  assign bus.lt     = res_q[0];
  assign bus.err    = err_q;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl: one early-exit and one full-width instance,
// each paired with a behavioural 1-bit cascade cell.
module tb_serial_compare_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1;
  logic rst0;
  logic inject1;
  int   run1;
  int   checks   = 0;
  int   failures = 0;

  serial_compare_ctrl_if #(.WIDTH(W)) if1 ();
  serial_compare_ctrl_if #(.WIDTH(W)) if0 ();

  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
  serial_compare_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst(rst0), .bus(if0));

  // RUN-cycle index of dut1, so the cell model knows which operand bit is on the wire.
  always @(posedge clk) begin
    run1 <= (if1.busy && !if1.done) ? run1 + 1 : 0;
  end

  always_comb begin
    if1.cell_eq = if1.cas_eq & (if1.bit_a ~^ if1.bit_b);
    if1.cell_gt = if1.cas_gt | (if1.cas_eq & if1.bit_a & ~if1.bit_b);
    if1.cell_lt = if1.cas_lt | (if1.cas_eq & ~if1.bit_a & if1.bit_b);
    if (inject1 && if1.busy && !if1.done && (W - 1 - run1) == 5) begin
      if1.cell_gt = 1'b1;
      if1.cell_lt = 1'b1;
    end
  end

  always_comb begin
    if0.cell_eq = if0.cas_eq & (if0.bit_a ~^ if0.bit_b);
    if0.cell_gt = if0.cas_gt | (if0.cas_eq & if0.bit_a & ~if0.bit_b);
    if0.cell_lt = if0.cas_lt | (if0.cas_eq & ~if0.bit_a & if0.bit_b);
  end

  task automatic go1(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
    @(negedge clk);
    if1.a = av; if1.b = bv; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    lat = 0;
    while (!if1.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!if1.done) lat = -1;
  endtask

  task automatic go0(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
    @(negedge clk);
    if0.a = av; if0.b = bv; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    lat = 0;
    while (!if0.done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!if0.done) lat = -1;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    rst1 = 1'b1; rst0 = 1'b1;
    if1.start = 1'b1; if1.a = 8'h12; if1.b = 8'h34;
    if0.start = 1'b1; if0.a = 8'h12; if0.b = 8'h34;
    repeat (3) @(negedge clk);
    obs = {if1.busy, if1.done, if1.eq, if1.gt, if1.lt, if1.err,
           if1.bit_a, if1.bit_b, if1.cas_eq, if1.cas_gt, if1.cas_lt};
    checks++;
    if (obs !== 11'd0) begin
      failures++; $display("FAIL reset_dut1: got %b expected %b", obs, 11'd0);
    end
    obs = {if0.busy, if0.done, if0.eq, if0.gt, if0.lt, if0.err,
           if0.bit_a, if0.bit_b, if0.cas_eq, if0.cas_gt, if0.cas_lt};
    checks++;
    if (obs !== 11'd0) begin
      failures++; $display("FAIL reset_dut0: got %b expected %b", obs, 11'd0);
    end
    rst1 = 1'b0; rst0 = 1'b0; if1.start = 1'b0; if0.start = 1'b0;
    @(negedge clk);
    checks++;
    if (if1.busy !== 1'b0) begin
      failures++; $display("FAIL reset_idle_hold: busy=%b expected 0", if1.busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_equal();
    int lat;
    go1(8'hA5, 8'hA5, lat);
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL equal_latency: got %0d expected 8", lat); end
    checks++;
    if ({if1.eq, if1.gt, if1.lt} !== 3'b100) begin
      failures++; $display("FAIL equal_result: got %b expected 100", {if1.eq, if1.gt, if1.lt});
    end
    @(negedge clk);
    checks++;
    if ({if1.done, if1.busy} !== 2'b00) begin
      failures++; $display("FAIL done_single_pulse: done,busy=%b expected 00", {if1.done, if1.busy});
    end
    checks++;
    if ({if1.eq, if1.gt, if1.lt} !== 3'b100) begin
      failures++; $display("FAIL result_held: got %b expected 100", {if1.eq, if1.gt, if1.lt});
    end
    $display("test_equal a=A5 b=A5 lat=%0d", lat);
  endtask

  task automatic test_early_exit();
    int lat;
    go1(8'h80, 8'h7F, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL early_latency: got %0d expected 1", lat); end
    checks++;
    if ({if1.eq, if1.gt, if1.lt} !== 3'b010) begin
      failures++; $display("FAIL early_result: got %b expected 010", {if1.eq, if1.gt, if1.lt});
    end
    $display("test_early_exit a=80 b=7F lat=%0d", lat);
    go1(8'h01, 8'hFF, lat);
    checks++;
    if (lat !== 1 || {if1.eq, if1.gt, if1.lt} !== 3'b001) begin
      failures++; $display("FAIL unsigned_lt: lat=%0d res=%b expected lat=1 res=001", lat, {if1.eq, if1.gt, if1.lt});
    end
    $display("test_early_exit a=01 b=FF lat=%0d", lat);
    go1(8'hFF, 8'hFE, lat);
    checks++;
    if (lat !== 8 || {if1.eq, if1.gt, if1.lt} !== 3'b010) begin
      failures++; $display("FAIL lsb_gt: lat=%0d res=%b expected lat=8 res=010", lat, {if1.eq, if1.gt, if1.lt});
    end
    $display("test_early_exit a=FF b=FE lat=%0d", lat);
  endtask

  task automatic test_full_no_exit();
    int lat;
    int lt_cycles;
    int last_lt;
    int cas_eq_cycles;
    int lat2;
    @(negedge clk);
    if0.a = 8'h3C; if0.b = 8'h3D; if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    lat = 0; lt_cycles = 0; last_lt = -1; cas_eq_cycles = 0;
    while (!if0.done && lat < 30) begin
      if (if0.cell_lt) begin lt_cycles++; last_lt = lat; end
      if (if0.cas_eq) cas_eq_cycles++;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8) begin failures++; $display("FAIL full_latency: got %0d expected 8", lat); end
    checks++;
    if (lt_cycles !== 1 || last_lt !== 7) begin
      failures++; $display("FAIL lt_final_cycle: lt_cycles=%0d at=%0d expected 1 at 7", lt_cycles, last_lt);
    end
    checks++;
    if (cas_eq_cycles !== 8) begin
      failures++; $display("FAIL cas_eq_cycles: got %0d expected 8", cas_eq_cycles);
    end
    checks++;
    if ({if0.eq, if0.gt, if0.lt} !== 3'b001) begin
      failures++; $display("FAIL full_result: got %b expected 001", {if0.eq, if0.gt, if0.lt});
    end
    $display("test_full_no_exit a=3C b=3D lat=%0d", lat);
    go0(8'h80, 8'h7F, lat2);
    checks++;
    if (lat2 !== 8 || {if0.eq, if0.gt, if0.lt} !== 3'b010) begin
      failures++; $display("FAIL no_exit_msb: lat=%0d res=%b expected lat=8 res=010", lat2, {if0.eq, if0.gt, if0.lt});
    end
    $display("test_full_no_exit a=80 b=7F lat=%0d", lat2);
  endtask

  task automatic test_start_held();
    int d0;
    int d1;
    int ndone;
    logic [2:0] r0;
    logic [2:0] r1;
    d0 = -1; d1 = -1; ndone = 0; r0 = 3'b000; r1 = 3'b000;
    @(negedge clk);
    if0.a = 8'd1; if0.b = 8'd2; if0.start = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (t == 2) begin if0.a = 8'hFF; if0.b = 8'h00; end
      if (if0.done) begin
        if (ndone == 0) begin d0 = t; r0 = {if0.eq, if0.gt, if0.lt}; end
        else if (ndone == 1) begin d1 = t; r1 = {if0.eq, if0.gt, if0.lt}; end
        ndone++;
      end
    end
    if0.start = 1'b0;
    checks++;
    if (ndone !== 2) begin failures++; $display("FAIL held_done_count: got %0d expected 2", ndone); end
    checks++;
    if (d0 !== 9 || (d1 - d0) !== 10) begin
      failures++; $display("FAIL held_spacing: first=%0d gap=%0d expected 9 and 10", d0, d1 - d0);
    end
    checks++;
    if (r0 !== 3'b001 || r1 !== 3'b010) begin
      failures++; $display("FAIL held_results: got %b,%b expected 001,010", r0, r1);
    end
    @(negedge clk);
    checks++;
    if (if0.busy !== 1'b0) begin failures++; $display("FAIL held_release: busy=%b expected 0", if0.busy); end
    $display("test_start_held first=%0d second=%0d", d0, d1);
  endtask

  task automatic test_reset_mid_run();
    logic [10:0] obs;
    int seen;
    int lat;
    @(negedge clk);
    if1.a = 8'h55; if1.b = 8'h55; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    repeat (3) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    obs = {if1.busy, if1.done, if1.eq, if1.gt, if1.lt, if1.err,
           if1.bit_a, if1.bit_b, if1.cas_eq, if1.cas_gt, if1.cas_lt};
    checks++;
    if (obs !== 11'd0) begin failures++; $display("FAIL midrun_reset: got %b expected %b", obs, 11'd0); end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (if1.done || if1.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL midrun_no_done: active cycles=%0d expected 0", seen); end
    go1(8'h00, 8'h00, lat);
    checks++;
    if (lat !== 8 || {if1.eq, if1.gt, if1.lt} !== 3'b100) begin
      failures++; $display("FAIL post_reset_run: lat=%0d res=%b expected lat=8 res=100", lat, {if1.eq, if1.gt, if1.lt});
    end
    $display("test_reset_mid_run then a=00 b=00 lat=%0d", lat);
  endtask

  task automatic test_err();
    int lat;
    inject1 = 1'b1;
    go1(8'h5A, 8'h5A, lat);
    checks++;
    if (lat !== 8 || if1.err !== 1'b1) begin
      failures++; $display("FAIL err_set: lat=%0d err=%b expected lat=8 err=1", lat, if1.err);
    end
    checks++;
    if ({if1.eq, if1.gt, if1.lt} !== 3'b111) begin
      failures++; $display("FAIL err_result: got %b expected 111", {if1.eq, if1.gt, if1.lt});
    end
    inject1 = 1'b0;
    @(negedge clk);
    checks++;
    if (if1.err !== 1'b1) begin failures++; $display("FAIL err_sticky: err=%b expected 1", if1.err); end
    go1(8'h5A, 8'h5A, lat);
    checks++;
    if (if1.err !== 1'b0 || {if1.eq, if1.gt, if1.lt} !== 3'b100) begin
      failures++; $display("FAIL err_clear: err=%b res=%b expected 0 and 100", if1.err, {if1.eq, if1.gt, if1.lt});
    end
    $display("test_err a=5A b=5A lat=%0d err=%b", lat, if1.err);
  endtask

  task automatic test_back_to_back();
    int lat;
    go1(8'h10, 8'h20, lat);
    checks++;
    if (lat !== 3 || {if1.eq, if1.gt, if1.lt} !== 3'b001) begin
      failures++; $display("FAIL b2b_first: lat=%0d res=%b expected lat=3 res=001", lat, {if1.eq, if1.gt, if1.lt});
    end
    go1(8'h20, 8'h10, lat);
    checks++;
    if (lat !== 3 || {if1.eq, if1.gt, if1.lt} !== 3'b010) begin
      failures++; $display("FAIL b2b_second: lat=%0d res=%b expected lat=3 res=010", lat, {if1.eq, if1.gt, if1.lt});
    end
    $display("test_back_to_back lat=%0d", lat);
  endtask

  initial begin
    inject1 = 1'b0;
    rst1 = 1'b1; rst0 = 1'b1;
    if1.start = 1'b0; if1.a = '0; if1.b = '0;
    if0.start = 1'b0; if0.a = '0; if0.b = '0;
    test_reset();
    test_equal();
    test_early_exit();
    test_full_no_exit();
    test_start_held();
    test_reset_mid_run();
    test_err();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
